// File: rtl/traffic_light_monitor.sv
`default_nettype none
// ============================================================================
// Module   : traffic_light_monitor
// Brief    : Safety monitor and lamp driver for a two-road light controller.
// Revision : 1.0 - initial release
// ============================================================================
module traffic_light_monitor #(
    parameter int MIN_YELLOW   = 3,
    parameter int MAX_STABLE   = 16,
    parameter int FLASH_HALF   = 4,
    parameter int ALL_RED_TIME = 8
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic [2:0] light_A_in,
    input  logic [2:0] light_B_in,
    input  logic       fault_clear,
    output logic [2:0] lamp_A,
    output logic [2:0] lamp_B,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam logic [2:0] c_GREEN  = 3'b001;
    localparam logic [2:0] c_YELLOW = 3'b010;
    localparam logic [2:0] c_RED    = 3'b100;
    localparam logic [2:0] c_OFF    = 3'b000;

    localparam logic [1:0] c_CODE_STALL = 2'b00;
    localparam logic [1:0] c_CODE_ENC   = 2'b01;
    localparam logic [1:0] c_CODE_CONF  = 2'b10;
    localparam logic [1:0] c_CODE_SEQ   = 2'b11;

    localparam int YW      = $clog2(MIN_YELLOW + 1);
    localparam int SW      = $clog2(MAX_STABLE + 1);
    localparam int CNT_MAX = (2 * FLASH_HALF > ALL_RED_TIME) ? 2 * FLASH_HALF : ALL_RED_TIME;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [YW-1:0] c_YMIN       = YW'(MIN_YELLOW);
    // The stall count trails the identical-sample run by one, so the limit
    // is hit when the registered count is two short of MAX_STABLE.
    localparam logic [SW-1:0] c_STALL_LIM  = SW'(MAX_STABLE - 2);
    localparam logic [CW-1:0] c_FLASH_HALF = CW'(FLASH_HALF);
    localparam logic [CW-1:0] c_FLASH_LAST = CW'(2 * FLASH_HALF - 1);
    localparam logic [CW-1:0] c_ALLRED     = CW'(ALL_RED_TIME);

    typedef enum logic [1:0] {
        S_PASS    = 2'd0,
        S_FLASH   = 2'd1,
        S_ALL_RED = 2'd2
    } state_t;

    state_t          r_state;
    logic [2:0]      r_lamp_A, r_lamp_B;
    logic            r_fault;
    logic [1:0]      r_fault_code;
    logic [2:0]      r_prev_A, r_prev_B;
    logic [YW-1:0]   r_ycnt_A, r_ycnt_B;
    logic [SW-1:0]   r_stall;
    logic [CW-1:0]   r_cnt;

    logic            w_enc_err, w_conf_err, w_seq_err, w_stall_err, w_viol;
    logic            w_same, w_legal_pair;
    logic [1:0]      w_code;
    logic [YW-1:0]   w_ycnt_A_nxt, w_ycnt_B_nxt;
    logic [CW-1:0]   w_flash_nxt;

    function automatic logic f_valid(input logic [2:0] c);
        return (c == c_GREEN) || (c == c_YELLOW) || (c == c_RED);
    endfunction

    function automatic logic f_seq_ok(input logic [2:0] p, input logic [2:0] c);
        return (p == c) ||
               (p == c_GREEN  && c == c_YELLOW) ||
               (p == c_YELLOW && c == c_RED)    ||
               (p == c_RED    && c == c_GREEN);
    endfunction

    function automatic logic [YW-1:0] f_ycnt(input logic [2:0] c, input logic [YW-1:0] n);
        if (c != c_YELLOW) return '0;
        return (n == c_YMIN) ? n : n + YW'(1);
    endfunction

    always_comb begin
        w_same       = ({light_A_in, light_B_in} == {r_prev_A, r_prev_B});
        w_enc_err    = !f_valid(light_A_in) || !f_valid(light_B_in);
        w_conf_err   = (light_A_in != c_RED) && (light_B_in != c_RED);
        w_seq_err    = !f_seq_ok(r_prev_A, light_A_in) || !f_seq_ok(r_prev_B, light_B_in) ||
                       (r_prev_A == c_YELLOW && light_A_in == c_RED && r_ycnt_A < c_YMIN) ||
                       (r_prev_B == c_YELLOW && light_B_in == c_RED && r_ycnt_B < c_YMIN);
        w_stall_err  = w_same && (r_stall == c_STALL_LIM);
        w_viol       = w_enc_err || w_conf_err || w_seq_err || w_stall_err;
        w_code       = w_enc_err  ? c_CODE_ENC  :
                       w_conf_err ? c_CODE_CONF :
                       w_seq_err  ? c_CODE_SEQ  : c_CODE_STALL;
        w_legal_pair = (light_A_in == c_GREEN && light_B_in == c_RED) ||
                       (light_A_in == c_RED   && light_B_in == c_GREEN);
        w_ycnt_A_nxt = f_ycnt(light_A_in, r_ycnt_A);
        w_ycnt_B_nxt = f_ycnt(light_B_in, r_ycnt_B);
        w_flash_nxt  = (r_cnt == c_FLASH_LAST) ? '0 : r_cnt + CW'(1);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_PASS;
            r_lamp_A     <= c_RED;
            r_lamp_B     <= c_RED;
            r_fault      <= 1'b0;
            r_fault_code <= c_CODE_STALL;
            r_prev_A     <= c_RED;
            r_prev_B     <= c_RED;
            r_ycnt_A     <= '0;
            r_ycnt_B     <= '0;
            r_stall      <= '0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                S_PASS: begin
                    if (w_viol) begin
                        r_state      <= S_FLASH;
                        r_fault      <= 1'b1;
                        r_fault_code <= w_code;
                        r_lamp_A     <= c_RED;
                        r_lamp_B     <= c_RED;
                        r_cnt        <= '0;
                    end else begin
                        r_lamp_A <= light_A_in;
                        r_lamp_B <= light_B_in;
                        r_prev_A <= light_A_in;
                        r_prev_B <= light_B_in;
                        r_ycnt_A <= w_ycnt_A_nxt;
                        r_ycnt_B <= w_ycnt_B_nxt;
                        r_stall  <= w_same ? r_stall + SW'(1) : '0;
                    end
                end
                S_FLASH: begin
                    if (fault_clear) begin
                        r_state  <= S_ALL_RED;
                        r_lamp_A <= c_RED;
                        r_lamp_B <= c_RED;
                        r_cnt    <= '0;
                    end else begin
                        r_cnt    <= w_flash_nxt;
                        r_lamp_A <= (w_flash_nxt < c_FLASH_HALF) ? c_RED : c_OFF;
                        r_lamp_B <= (w_flash_nxt < c_FLASH_HALF) ? c_RED : c_OFF;
                    end
                end
                S_ALL_RED: begin
                    if (r_cnt < c_ALLRED) begin
                        r_cnt    <= r_cnt + CW'(1);
                        r_lamp_A <= c_RED;
                        r_lamp_B <= c_RED;
                    end else if (w_legal_pair) begin
                        r_state  <= S_PASS;
                        r_fault  <= 1'b0;
                        r_prev_A <= light_A_in;
                        r_prev_B <= light_B_in;
                        r_lamp_A <= light_A_in;
                        r_lamp_B <= light_B_in;
                        r_ycnt_A <= '0;
                        r_ycnt_B <= '0;
                        r_stall  <= '0;
                        r_cnt    <= '0;
                    end else begin
                        r_lamp_A <= c_RED;
                        r_lamp_B <= c_RED;
                    end
                end
                default: r_state <= S_PASS;
            endcase
        end
    end

    assign lamp_A     = r_lamp_A;
    assign lamp_B     = r_lamp_B;
    assign fault      = r_fault;
    assign fault_code = r_fault_code;

endmodule
`default_nettype wire
